// File: rtl/seq_multiplier_4x4.sv
// Sequential 4x4 unsigned multiplier.
// Builds the 8-bit product from four 2x2 partial products, one per CALC cycle,
// behind a valid/ready handshake on both the operand and product sides.
module seq_multiplier_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] p,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  step_q, step_d;

  logic [1:0]  a_pair;
  logic [1:0]  b_pair;
  logic [3:0]  pp;
  logic [2:0]  shamt;
  logic [7:0]  pp_shifted;
  logic        accept;

  assign accept = (state_q == StIdle) && in_valid;

  // Step k selects i=k[1] for the a pair and j=k[0] for the b pair; shift is 2*(i+j).
  assign a_pair     = step_q[1] ? a_q[3:2] : a_q[1:0];
  assign b_pair     = step_q[0] ? b_q[3:2] : b_q[1:0];
  assign pp         = {2'b00, a_pair} * {2'b00, b_pair};
  assign shamt      = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 1'b0};
  assign pp_shifted = {4'b0000, pp} << shamt;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid)       state_d = StCalc;
      StCalc: if (step_q == 2'd3) state_d = StDone;
      StDone: if (out_ready)      state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // Handshake and status outputs; all forced low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q == StCalc) || (state_q == StDone);
    end
  end

  // Datapath next-state: capture operands on accept, accumulate during CALC.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    step_d = step_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      acc_d  = 8'h00;
      step_d = 2'd0;
    end else if (state_q == StCalc) begin
      acc_d  = acc_q + pp_shifted;
      step_d = step_q + 2'd1;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 4'h0;
      b_q    <= 4'h0;
      acc_q  <= 8'h00;
      step_q <= 2'd0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  // Product holds after DONE->IDLE until the next accept clears the accumulator.
  assign p = acc_q;

endmodule

// File: tb/tb_seq_multiplier_4x4.sv
// Self-checking bench for seq_multiplier_4x4 using an expected-product queue.
module tb_seq_multiplier_4x4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       busy;

  logic [7:0] exp_q[$];
  int n_checks;
  int n_pass;

  seq_multiplier_4x4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair for one edge and record its expected product.
  task automatic drive_accept(input logic [3:0] av, input logic [3:0] bv);
    logic [7:0] prod;
    prod = {4'h0, av} * {4'h0, bv};
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(prod);
  endtask

  // Wait for out_valid, bounded; returns edges elapsed.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 4'h0;
    b = 4'h0;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (p !== 8'h00) $display("FAIL reset_p: got %h expected 00", p);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    logic [7:0] e;
    out_ready = 1'b1;
    drive_accept(4'd3, 4'd2);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_busy_after_accept: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
    else n_pass++;
    wait_out(cyc);
    n_checks++;
    if (cyc != 4) $display("FAIL basic_latency: got %0d expected 4", cyc);
    else n_pass++;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL basic_queue: got empty expected 1 entry");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (p !== e) $display("FAIL basic_p: got %h expected %h", p, e);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_values();
    logic [3:0] ta[6] = '{4'd15, 4'd0, 4'd10, 4'd1, 4'd12, 4'd6};
    logic [3:0] tb[6] = '{4'd15, 4'd9, 4'd5, 4'd14, 4'd11, 4'd3};
    int cyc;
    logic [7:0] e;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      drive_accept(ta[t], tb[t]);
      wait_out(cyc);
      n_checks++;
      if (cyc != 4) $display("FAIL values_latency[%0d]: got %0d expected 4", t, cyc);
      else n_pass++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL values_queue[%0d]: got empty expected 1 entry", t);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (p !== e) $display("FAIL values_p[%0d]: got %h expected %h", t, p, e);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [7:0] e;
    out_ready = 1'b0;
    drive_accept(4'd7, 4'd13);
    wait_out(cyc);
    n_checks++;
    if (cyc != 4) $display("FAIL bp_latency: got %0d expected 4", cyc);
    else n_pass++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || p !== e || in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b p=%h rdy=%b expected 1/%h/0",
                 i, out_valid, p, in_ready, e);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b1 || p !== 8'h5B)
      $display("FAIL bp_final: got v=%b p=%h expected 1/5b", out_valid, p);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_single_handshake: got v=%b rdy=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] e;
    out_ready = 1'b1;
    a = 4'd9;
    b = 4'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    // Now in step 2.
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || p !== 8'h00 || busy !== 1'b0)
      $display("FAIL rstmid_abort: got v=%b p=%h busy=%b expected 0/00/0", out_valid, p, busy);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rstmid_idle: got rdy=%b busy=%b expected 1/0", in_ready, busy);
    else n_pass++;
    drive_accept(4'd2, 4'd3);
    wait_out(cyc);
    n_checks++;
    if (cyc != 4) $display("FAIL rstmid_latency: got %0d expected 4", cyc);
    else n_pass++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (p !== e) $display("FAIL rstmid_p: got %h expected %h", p, e);
    else n_pass++;
    tick();
  endtask

  task automatic test_stability();
    int cyc;
    logic [7:0] e;
    out_ready = 1'b1;
    drive_accept(4'd5, 4'd6);
    a = 4'd15;
    b = 4'd15;
    in_valid = 1'b1;
    wait_out(cyc);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (p !== e || e !== 8'h1E) $display("FAIL stability_p: got %h expected 1e", p);
    else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int last;
    int n_acc;
    logic [7:0] e;
    last = -1;
    n_acc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      #1;
      if (in_ready === 1'b1) begin
        e = {4'h0, a} * {4'h0, b};
        exp_q.push_back(e);
        if (last >= 0) begin
          n_checks++;
          if (c - last != 6) $display("FAIL b2b_spacing: got %0d expected 6", c - last);
          else n_pass++;
        end
        last = c;
        n_acc++;
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_spurious_output: got p=%h expected none", p);
        else begin
          e = exp_q.pop_front();
          if (p !== e) $display("FAIL b2b_p: got %h expected %h", p, e);
          else n_pass++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (out_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (p !== e) $display("FAIL b2b_drain_p: got %h expected %h", p, e);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0 || n_acc < 6)
      $display("FAIL b2b_complete: got pending=%0d accepts=%0d expected 0/>=6",
               exp_q.size(), n_acc);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 4'h0;
    b = 4'h0;
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_stability();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_4x4.md
SEQ_MULTIPLIER_4X4 -- requirements
Module: seq_multiplier_4x4

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  4  unsigned multiplicand.
REQ-007 b  input  4  unsigned multiplier.
REQ-008 out_valid  output  1  product on p is valid.
REQ-009 out_ready  input  1  downstream accepts p.
REQ-010 p  output  8  unsigned product a*b.
REQ-011 busy  output  1  high in CALC and DONE states.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE with rst low; it SHALL be 0 in CALC and DONE.
REQ-014 Accept: at a rising edge with in_valid=1 and in_ready=1, the block SHALL latch a and b into internal operand registers, clear the 8-bit accumulator, clear the 2-bit step counter, and go IDLE->CALC.
REQ-015 Changes on a/b after acceptance SHALL NOT affect the result.
REQ-016 IDLE with in_valid=0 SHALL remain IDLE.
REQ-017 CALC SHALL last exactly 4 cycles, one per step k=0..3, with i=k[1] and j=k[0].
REQ-018 At each CALC edge the block SHALL form the 4-bit 2x2 partial product A[2i+1:2i]*B[2j+1:2j] and add it, shifted left by 2*(i+j), to the accumulator.
REQ-019 Step shifts: k0=0, k1=2, k2=2, k3=4.
REQ-020 The accumulator SHALL be 8 bits; the maximum result is 15*15=225 (0xE1), so no overflow handling is needed.
REQ-021 At the edge completing step 3, the block SHALL go CALC->DONE, and out_valid SHALL be 1 from the following cycle.
REQ-022 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-023 In DONE, p SHALL equal the accumulator and SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 At a rising edge in DONE with out_ready=1, the block SHALL go DONE->IDLE; out_valid SHALL fall and in_ready SHALL rise in the next cycle.
REQ-025 Throughput: at most one operation per 6 cycles (accept, 4x CALC, 1+ DONE); accept and output SHALL never occur on the same edge.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 in_valid SHALL be ignored outside IDLE.
REQ-028 p SHALL hold the last product after DONE->IDLE until the next accept clears it; p is meaningful only while out_valid=1.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL enter IDLE and clear the operand registers, accumulator (p=0x00) and step counter.
REQ-030 While rst=1, out_valid=0, busy=0 and in_ready=0.
REQ-031 rst SHALL take priority over all handshakes.
REQ-032 rst asserted in CALC or DONE SHALL abandon the operation with no output produced.
REQ-033 The block SHALL accept a new operand pair from the first cycle after rst falls.

Verification
REQ-034 Reset, then a=3, b=2, in_valid pulsed for one cycle, out_ready=1 -> accepted at edge E0; out_valid=1 after E4 with p=0x06; in_ready=1 again one cycle after the output handshake.
REQ-035 a=15, b=15 -> p=0xE1 (225), with latency exactly 4 edges; a=0, b=9 -> p=0x00; a=10, b=5 -> p=0x32.
REQ-036 Backpressure: a=7, b=13, out_ready=0 for 5 cycles after out_valid rises, then 1 -> p=0x5B held stable every cycle; exactly one output handshake; in_ready stays 0 throughout.
REQ-037 Reset mid-operation: accept a=9, b=9, assert rst during step 2 -> next cycle out_valid=0, p=0x00, busy=0; a following accept of a=2, b=3 yields p=0x06.
REQ-038 Operand stability: after accepting a=5, b=6, drive a=15, b=15 during CALC -> p=0x1E.
REQ-039 Back-to-back: in_valid held high with changing operands and out_ready=1 -> exactly one accept per operation, spaced 6 cycles apart, and every p correct.
